mem_arbiter: RTL
================

# mem_arbiter

Memory-side responder for the datapath/cache request interface. It accepts the datapath's instruction fetch (imemREN/imemaddr) and data (dmemREN/dmemWEN/dmemaddr/dmemstore) requests, arbitrates them onto one single-ported RAM with variable latency, and returns ihit/dhit with imemload/dmemload. It sits between the datapath and the RAM model, in place of a cache in cacheless builds.

## Interface
- ADDR_W, 32, byte address width of imemaddr, dmemaddr, ramaddr
- DATA_W, 32, word width of all data buses
- CLK  in  1  system clock; all state updates on rising edge
- nRST  in  1  asynchronous, active-low reset
- halt  in  1  datapath halted; blocks new instruction grants
- imemREN  in  1  instruction read request
- imemaddr  in  ADDR_W  instruction address, word aligned
- ihit  out  1  instruction read complete this cycle
- imemload  out  DATA_W  fetched instruction, valid when ihit=1
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request (never with dmemREN)
- dmemaddr  in  ADDR_W  data address, word aligned
- dmemstore  in  DATA_W  write data
- dhit  out  1  data access complete this cycle
- dmemload  out  DATA_W  read data, valid when dhit=1 and dmemREN=1
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ramstate=ACCESS
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  out  1  sticky: a RAM ERROR was returned since reset

## Operation
- FSM states IDLE, IBUSY, DBUSY; reset state IDLE.
- IDLE: data request (dmemREN|dmemWEN) has priority. Drive RAM combinationally from the winning request; if ramstate=ACCESS in the same cycle, assert the matching hit and stay IDLE; if BUSY/FREE, go DBUSY (data) or IBUSY (instruction).
- Instruction grant in IDLE only when imemREN=1, halt=0, and no data request.
- DBUSY/IBUSY: owner locked; keep driving owner's address/enables even if the other side raises a request. On ACCESS: one-cycle hit, back to IDLE. If the owner drops its request before ACCESS: RAM enables drop, no hit, IDLE.
- ERROR in any owning cycle: no hit, set mem_err, return IDLE (request retried next cycle).
- ramREN = owner is data read or instruction; ramWEN = owner is data write; ramstore = dmemstore. Never both ramREN and ramWEN.
- imemload = ramload (or buffer, see Configuration); dmemload = ramload.
- Reset (asynchronous, any time, including mid-access): state IDLE, ihit=0, dhit=0, ramREN=0, ramWEN=0, ramaddr=0, mem_err=0, buffer invalid; in-flight access abandoned with no hit.

## Timing
- Hit outputs are combinational from ramstate in the owning cycle; datapath samples them at the next rising CLK.
- Latency: N cycles of BUSY before ACCESS gives hit in cycle N+1 after grant; zero-wait RAM gives same-cycle hit.
- Back-to-back: after dhit, an instruction request held high is granted in the very next cycle (IDLE).
- Exactly one hit per completed access; ihit and dhit never both 1.

## Configuration
- MEM_ARBITER_IBUF_EN defined: one-entry instruction buffer (valid, tag, word). Loaded on every ihit from RAM. In IDLE, imemREN=1, halt=0, no data request, valid=1 and imemaddr=tag: ihit=1 same cycle, imemload=buffer word, no RAM access. A data write with dmemaddr=tag at dhit clears valid; reset clears valid.
- Not defined: no buffer; every fetch goes to RAM.

## Test plan
- Reset mid-DBUSY with ramWEN=1: nRST low -> ramWEN=0, dhit=0, state IDLE immediately, mem_err=0.
- imemREN=1 addr 0x40, dmemREN=1 addr 0x80 simultaneous, RAM latency 2 -> ramaddr=0x80 for 3 cycles, dhit once, then ramaddr=0x40 and ihit after 3 more cycles.
- Zero-latency RAM, imemREN=1 addr 0x0, ramload 0x3C010001 -> ihit=1 same cycle, imemload=0x3C010001.
- dmemREN raised while IBUSY (latency 3) -> ramaddr stays on instruction until ihit; dhit follows after its own latency.
- ramstate=ERROR on data read -> no dhit, mem_err=1 and stays 1; retry completes with dhit.
- MEM_ARBITER_IBUF_EN: fetch 0x10 twice -> second ihit with ramREN=0; write to 0x10 then fetch -> RAM accessed again.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates datapath instruction/data requests onto one single-ported, variable-latency RAM.
// Optional one-entry instruction buffer is enabled by defining MEM_ARBITER_IBUF_EN.
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] imemload,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] dmemaddr,
    input  logic [DATA_W-1:0] dmemstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic dreq;
    logic ireq;
    logic own_d;
    logic own_i;
    logic buf_use;
    logic buf_hit;
    logic ram_err;
    logic ram_ihit;

    assign dreq     = dmemREN | dmemWEN;
    assign ireq     = imemREN & ~halt;
    assign ramstore = dmemstore;
    assign dmemload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mem_err <= 1'b0;
        end else if (ram_err) begin
            mem_err <= 1'b1;
        end
    end

    // Outputs are forced quiet while nRST is low so an in-flight access is dropped at once.
    always_comb begin
        state_next = state;
        own_d      = 1'b0;
        own_i      = 1'b0;
        buf_use    = 1'b0;
        ram_ihit   = 1'b0;
        ram_err    = 1'b0;
        ihit       = 1'b0;
        dhit       = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (dreq) begin
                        own_d = 1'b1;
                    end else if (ireq) begin
                        if (buf_hit) begin
                            buf_use = 1'b1;
                        end else begin
                            own_i = 1'b1;
                        end
                    end
                end
                DBUSY: begin
                    if (dreq) begin
                        own_d = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                IBUSY: begin
                    if (imemREN) begin
                        own_i = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (own_d) begin
                ramREN  = dmemREN & ~dmemWEN;
                ramWEN  = dmemWEN;
                ramaddr = dmemaddr;
            end else if (own_i) begin
                ramREN  = 1'b1;
                ramaddr = imemaddr;
            end

            // An ERROR completes nothing; the still-asserted request is regranted from IDLE.
            if (own_d || own_i) begin
                if (ramstate == RAM_ACCESS) begin
                    dhit       = own_d;
                    ram_ihit   = own_i;
                    state_next = IDLE;
                end else if (ramstate == RAM_ERROR) begin
                    ram_err    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = own_d ? DBUSY : IBUSY;
                end
            end

            ihit = ram_ihit | buf_use;
        end
    end

`ifdef MEM_ARBITER_IBUF_EN
    logic              ibuf_valid;
    logic [ADDR_W-1:0] ibuf_tag;
    logic [DATA_W-1:0] ibuf_word;

    assign buf_hit  = ibuf_valid && (imemaddr == ibuf_tag);
    assign imemload = buf_use ? ibuf_word : ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ibuf_valid <= 1'b0;
            ibuf_tag   <= '0;
            ibuf_word  <= '0;
        end else if (ram_ihit) begin
            ibuf_valid <= 1'b1;
            ibuf_tag   <= imemaddr;
            ibuf_word  <= ramload;
        end else if (dhit && dmemWEN && (dmemaddr == ibuf_tag)) begin
            ibuf_valid <= 1'b0;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign imemload = ramload;
`endif

endmodule

`default_nettype wire
